// File: rtl/button_cmd_encoder_pkg.sv
// button_cmd_encoder_pkg: command codes, FSM state encoding and press priority
// shared by the button front end and the display FSM.
package button_cmd_encoder_pkg;
    localparam logic [2:0] CMD_NONE = 3'b000;
    localparam logic [2:0] CMD_A    = 3'b001;
    localparam logic [2:0] CMD_B    = 3'b010;
    localparam logic [2:0] CMD_P    = 3'b011;
    localparam logic [2:0] CMD_C    = 3'b100;
    localparam logic [2:0] CMD_E    = 3'b101;
    localparam logic [2:0] CMD_G    = 3'b110;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EMIT     = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    // Lowest-index press wins; simultaneous higher-index presses are dropped.
    function automatic logic [2:0] press_code(input logic [5:0] rise);
        return rise[0] ? CMD_A :
               rise[1] ? CMD_B :
               rise[2] ? CMD_P :
               rise[3] ? CMD_C :
               rise[4] ? CMD_E :
               rise[5] ? CMD_G : CMD_NONE;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus consecutive-disagreement counter
// for one raw button; rise pulses for one cycle after the level goes high.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic flip;

    assign flip = (sync[1] != level) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
            level <= flip ? sync[1] : level;
            rise  <= flip & sync[1];
        end
    end
endmodule

// File: rtl/button_cmd_encoder.sv
// button_cmd_encoder: debounces six buttons and emits one held command code
// per physical press, then waits for all buttons to be released.
module button_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       busy
);
    import button_cmd_encoder_pkg::*;

    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [5:0] level;
    logic [5:0] rise;
    logic [1:0] state;
    logic [HW-1:0] hold;

    genvar i;
    generate
        for (i = 0; i < 6; i++) begin : g_btn
            btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn[i]),
                .level(level[i]),
                .rise (rise[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold      <= '0;
            cmd       <= CMD_NONE;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (|rise) begin
                    state     <= ST_EMIT;
                    cmd       <= press_code(rise);
                    cmd_valid <= 1'b1;
                    busy      <= 1'b1;
                    hold      <= HOLD_LOAD;
                end
                ST_EMIT: if (hold == '0) begin
                    state     <= ST_WAIT_REL;
                    cmd       <= CMD_NONE;
                    cmd_valid <= 1'b0;
                end else begin
                    hold <= hold - 1'b1;
                end
                ST_WAIT_REL: if (~|level) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd       <= CMD_NONE;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
